// File: rtl/timer_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : timer_cfg_seq
// Description : APB4 master that programs the timer, starts it, services its
//               interrupt (read TISR, W1C clear) and then stops it or reloads
//               it for periodic operation.
// Revision    : 1.0  initial release
// ============================================================================
module timer_cfg_seq #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [63:0]      cfg_cmp,
  input  logic             cfg_div_en,
  input  logic [3:0]       cfg_div_val,
  input  logic             cfg_periodic,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] irq_cnt,
  output logic             tim_psel,
  output logic             tim_penable,
  output logic             tim_pwrite,
  output logic [11:0]      tim_paddr,
  output logic [31:0]      tim_pwdata,
  output logic [3:0]       tim_pstrb,
  input  logic [31:0]      tim_prdata,
  input  logic             tim_pready,
  input  logic             tim_pslverr,
  input  logic             tim_int
);

  localparam int                 C_TMO_W    = $clog2(TIMEOUT);
  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT - 1);
  localparam logic [11:0] C_A_TCR   = 12'h000;
  localparam logic [11:0] C_A_TDR0  = 12'h004;
  localparam logic [11:0] C_A_TDR1  = 12'h008;
  localparam logic [11:0] C_A_TCMP0 = 12'h00C;
  localparam logic [11:0] C_A_TCMP1 = 12'h010;
  localparam logic [11:0] C_A_TIER  = 12'h014;
  localparam logic [11:0] C_A_TISR  = 12'h018;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_GAP    = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  // Which operation list the op pointer (idx) walks through.
  typedef enum logic [2:0] {
    L_PROG   = 3'd0,
    L_SVC_RD = 3'd1,
    L_SVC_WR = 3'd2,
    L_RELOAD = 3'd3,
    L_FINISH = 3'd4,
    L_STOP   = 3'd5
  } list_t;

  state_t             state_q, state_d;
  list_t              list_q, list_d;
  logic [2:0]         idx_q, idx_d;
  logic [C_TMO_W-1:0] tmo_q, tmo_d;
  logic               hit_q, hit_d;
  logic               stop_pend_q, stop_pend_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   irq_cnt_q, irq_cnt_d;
  logic [63:0]        cmp_q, cmp_d;
  logic               div_en_q, div_en_d;
  logic [3:0]         div_val_q, div_val_d;
  logic               periodic_q, periodic_d;

  logic               op_write;
  logic [11:0]        op_addr;
  logic [31:0]        op_wdata;
  logic [31:0]        tcr_off;
  logic               w_xfer;
  logic               w_last;
  logic               w_stop;
  logic               w_stop_imm;
  logic [30:0]        unused_prdata;

  assign unused_prdata = tim_prdata[31:1];

  // Decode the current op pointer into an APB write/read with address and data.
  always_comb begin
    tcr_off  = {20'b0, div_val_q, 6'b0, div_en_q, 1'b0};
    op_write = 1'b1;
    op_addr  = C_A_TCR;
    op_wdata = tcr_off;
    case (list_q)
      L_PROG: begin
        case (idx_q)
          3'd0:    begin op_addr = C_A_TCR;   op_wdata = tcr_off;        end
          3'd1:    begin op_addr = C_A_TDR0;  op_wdata = 32'd0;          end
          3'd2:    begin op_addr = C_A_TDR1;  op_wdata = 32'd0;          end
          3'd3:    begin op_addr = C_A_TCMP0; op_wdata = cmp_q[31:0];    end
          3'd4:    begin op_addr = C_A_TCMP1; op_wdata = cmp_q[63:32];   end
          3'd5:    begin op_addr = C_A_TISR;  op_wdata = 32'd1;          end
          3'd6:    begin op_addr = C_A_TIER;  op_wdata = 32'd1;          end
          default: begin op_addr = C_A_TCR;   op_wdata = tcr_off | 32'd1; end
        endcase
      end
      L_SVC_RD: begin
        op_write = 1'b0;
        op_addr  = C_A_TISR;
        op_wdata = 32'd0;
      end
      L_SVC_WR: begin
        op_addr  = C_A_TISR;
        op_wdata = 32'd1;
      end
      L_RELOAD: begin
        case (idx_q)
          3'd0:    begin op_addr = C_A_TCR;  op_wdata = tcr_off;         end
          3'd1:    begin op_addr = C_A_TDR0; op_wdata = 32'd0;           end
          3'd2:    begin op_addr = C_A_TDR1; op_wdata = 32'd0;           end
          default: begin op_addr = C_A_TCR;  op_wdata = tcr_off | 32'd1; end
        endcase
      end
      L_FINISH: begin
        if (idx_q != 3'd0) begin
          op_addr  = C_A_TIER;
          op_wdata = 32'd0;
        end
      end
      default: begin
        case (idx_q)
          3'd0:    begin op_addr = C_A_TCR;  op_wdata = tcr_off; end
          3'd1:    begin op_addr = C_A_TIER; op_wdata = 32'd0;   end
          default: begin op_addr = C_A_TISR; op_wdata = 32'd1;   end
        endcase
      end
    endcase
  end

  // The final op of each list decides where the sequencer goes next.
  assign w_last = ((list_q == L_PROG)   && (idx_q == 3'd7)) ||
                  ((list_q == L_RELOAD) && (idx_q == 3'd3)) ||
                  ((list_q == L_FINISH) && (idx_q == 3'd1)) ||
                  ((list_q == L_STOP)   && (idx_q == 3'd2)) ||
                  (list_q == L_SVC_RD) || (list_q == L_SVC_WR);

  // Once the timer is already being shut down a further stop has nothing to add.
  assign w_stop_imm = (list_q == L_FINISH) || (list_q == L_STOP);
  assign w_stop     = stop_pend_q || cfg_stop;

  // Sequencer next-state: APB phases, op pointer, stop/error/timeout handling.
  always_comb begin
    state_d     = state_q;
    list_d      = list_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    hit_d       = hit_q;
    stop_pend_d = stop_pend_q;
    err_d       = err_q;
    irq_cnt_d   = irq_cnt_q;
    cmp_d       = cmp_q;
    div_en_d    = div_en_q;
    div_val_d   = div_val_q;
    periodic_d  = periodic_q;

    if (cfg_stop && (state_q != S_IDLE) && !w_stop_imm) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d     = S_SETUP;
          list_d      = L_PROG;
          idx_d       = 3'd0;
          hit_d       = 1'b0;
          stop_pend_d = 1'b0;
          err_d       = 1'b0;
          irq_cnt_d   = '0;
          cmp_d       = cfg_cmp;
          div_en_d    = cfg_div_en;
          div_val_d   = cfg_div_val;
          periodic_d  = cfg_periodic;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        tmo_d   = '0;
      end
      S_ACCESS: begin
        if (tim_pready) begin
          if (tim_pslverr) begin
            err_d       = 1'b1;
            state_d     = S_IDLE;
            idx_d       = 3'd0;
            stop_pend_d = 1'b0;
          end else begin
            state_d = S_GAP;
            if (list_q == L_SVC_RD) hit_d = tim_prdata[0];
            if (list_q == L_SVC_WR) irq_cnt_d = irq_cnt_q + CNT_W'(1);
          end
        end else if (tmo_q == C_TMO_LAST) begin
          err_d       = 1'b1;
          state_d     = S_IDLE;
          idx_d       = 3'd0;
          stop_pend_d = 1'b0;
        end else begin
          tmo_d = tmo_q + C_TMO_W'(1);
        end
      end
      S_GAP: begin
        if (w_stop && !w_stop_imm) begin
          state_d     = S_SETUP;
          list_d      = L_STOP;
          idx_d       = 3'd0;
          stop_pend_d = 1'b0;
        end else if (!w_last) begin
          state_d = S_SETUP;
          idx_d   = idx_q + 3'd1;
        end else begin
          idx_d = 3'd0;
          case (list_q)
            L_SVC_RD: begin
              if (hit_q) begin
                state_d = S_SETUP;
                list_d  = L_SVC_WR;
              end else begin
                state_d = S_WAIT;
              end
            end
            L_SVC_WR: begin
              state_d = S_SETUP;
              list_d  = periodic_q ? L_RELOAD : L_FINISH;
            end
            L_FINISH, L_STOP: begin
              state_d     = S_IDLE;
              stop_pend_d = 1'b0;
            end
            default: state_d = S_WAIT;
          endcase
        end
      end
      S_WAIT: begin
        if (w_stop) begin
          state_d     = S_SETUP;
          list_d      = L_STOP;
          idx_d       = 3'd0;
          stop_pend_d = 1'b0;
        end else if (tim_int) begin
          state_d = S_SETUP;
          list_d  = L_SVC_RD;
          idx_d   = 3'd0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        idx_d       = 3'd0;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  // State and captured configuration registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      list_q      <= L_PROG;
      idx_q       <= 3'd0;
      tmo_q       <= '0;
      hit_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      err_q       <= 1'b0;
      irq_cnt_q   <= '0;
      cmp_q       <= 64'd0;
      div_en_q    <= 1'b0;
      div_val_q   <= 4'd0;
      periodic_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      list_q      <= list_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      hit_q       <= hit_d;
      stop_pend_q <= stop_pend_d;
      err_q       <= err_d;
      irq_cnt_q   <= irq_cnt_d;
      cmp_q       <= cmp_d;
      div_en_q    <= div_en_d;
      div_val_q   <= div_val_d;
      periodic_q  <= periodic_d;
    end
  end

  // APB fields are driven only during SETUP/ACCESS and are zero otherwise.
  assign w_xfer      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign tim_psel    = w_xfer;
  assign tim_penable = (state_q == S_ACCESS);
  assign tim_pwrite  = w_xfer && op_write;
  assign tim_paddr   = w_xfer ? op_addr : 12'h000;
  assign tim_pwdata  = (w_xfer && op_write) ? op_wdata : 32'd0;
  assign tim_pstrb   = (w_xfer && op_write) ? 4'hF : 4'h0;

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_ACCESS) && (list_q == L_SVC_WR) && tim_pready && !tim_pslverr;
  assign err     = err_q;
  assign irq_cnt = irq_cnt_q;

endmodule
`default_nettype wire
